// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scanner: inactive output levels and the
// active-low hex-to-segment table, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus between the input-select stage (master) and the scanner (slave).
// frame_tick is a one-cycle pulse with no back-pressure: the codes sampled on
// the pulse's rising edge are what the next frame shows.
interface seven_seg_scan_if;

   logic [3:0] dispA;
   logic [3:0] dispB;
   logic [3:0] dispC;
   logic [3:0] dispD;
   logic [3:0] blank;
   logic [3:0] dp_en;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_tick;

   modport master (
      output dispA, dispB, dispC, dispD, blank, dp_en,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  dispA, dispB, dispC, dispD, blank, dp_en,
      output seg, dp, an, frame_tick
   );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit hex code to active-low 7-segment pattern.
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[code];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode scanner: shadows the digit codes once per frame and
// lights one digit per slot, with a one-cycle all-off gap between slots.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter  int REFRESH_DIV = 100000,
   localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   seven_seg_scan_if.slave  bus
);

   logic [CNT_W-1:0] presc;
   logic [1:0]       idx;
   logic [3:0]       sh_dig [4];
   logic [3:0]       sh_blank;
   logic [3:0]       sh_dp;

   logic             tick;
   logic [1:0]       bit_sel;
   logic [3:0]       cur_dig;
   logic             cur_blank;
   logic             cur_dp;
   logic [6:0]       dec_seg;

   assign tick      = (presc == CNT_W'(REFRESH_DIV - 1));
   // idx 0 is digit A, which lives in bit 3 of the blank/dp masks.
   assign bit_sel   = ~idx;
   assign cur_dig   = sh_dig[idx];
   assign cur_blank = sh_blank[bit_sel];
   assign cur_dp    = sh_dp[bit_sel];

   hex_to_7seg u_dec (
      .code (cur_dig),
      .seg  (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc          <= '0;
         idx            <= 2'd3;
         for (int i = 0; i < 4; i++) sh_dig[i] <= '0;
         sh_blank       <= '0;
         sh_dp          <= '0;
         bus.an         <= AN_OFF;
         bus.seg        <= SEG_OFF;
         bus.dp         <= 1'b1;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.frame_tick <= 1'b0;
         if (tick) begin
            presc  <= '0;
            idx    <= idx + 2'd1;
            bus.an <= AN_OFF;
            // Leaving digit D closes the frame: latch the next frame's codes.
            if (idx == 2'd3) begin
               sh_dig[0]      <= bus.dispA;
               sh_dig[1]      <= bus.dispB;
               sh_dig[2]      <= bus.dispC;
               sh_dig[3]      <= bus.dispD;
               sh_blank       <= bus.blank;
               sh_dp          <= bus.dp_en;
               bus.frame_tick <= 1'b1;
            end
         end else begin
            presc <= presc + 1'b1;
            if (cur_blank) begin
               bus.an  <= AN_OFF;
               bus.seg <= SEG_OFF;
               bus.dp  <= 1'b1;
            end else begin
               bus.an  <= ~(4'b1000 >> idx);
               bus.seg <= dec_seg;
               bus.dp  <= ~cur_dp;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan at REFRESH_DIV=4: timeline model checked every cycle
// plus directed literal checks of the scan sequence, tearing, blanking and reset.
module tb_seven_seg_scan;

   localparam int DIV = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seven_seg_scan_if bus ();

   seven_seg_scan #(.REFRESH_DIV(DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] hex_ref [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: edges since reset release define slot, digit and gap purely by arithmetic.
   int         n = 0;
   logic [3:0] m_dig [4];
   logic [3:0] m_blank, m_dp;
   logic [6:0] e_seg;
   logic [3:0] e_an;
   logic       e_dp, e_ft;
   bit         model_on = 0;

   always @(posedge clk) begin : model
      int pos, d;
      if (!rst_n) begin
         n = 0;
         for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
         m_blank = 4'h0;
         m_dp    = 4'h0;
         e_an    = 4'hF;
         e_seg   = 7'h7F;
         e_dp    = 1'b1;
         e_ft    = 1'b0;
      end else begin
         n++;
         pos  = (n - 1) % DIV;
         d    = (3 + (n - 1) / DIV) % 4;
         e_ft = 1'b0;
         if (pos == DIV - 1) begin
            e_an = 4'hF;
            if (d == 3) begin
               m_dig[0] = bus.dispA;
               m_dig[1] = bus.dispB;
               m_dig[2] = bus.dispC;
               m_dig[3] = bus.dispD;
               m_blank  = bus.blank;
               m_dp     = bus.dp_en;
               e_ft     = 1'b1;
            end
         end else if (m_blank[3-d]) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
         end else begin
            e_an  = ~(4'b1000 >> d);
            e_seg = hex_ref[m_dig[d]];
            e_dp  = ~m_dp[3-d];
         end
      end
      model_on = 1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("model_an",  7'(bus.an),         7'(e_an));
         chk("model_seg", bus.seg,            e_seg);
         chk("model_dp",  7'(bus.dp),         7'(e_dp));
         chk("model_ft",  7'(bus.frame_tick), 7'(e_ft));
      end
   end

   task automatic edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic set_digits(input logic [3:0] a, b, c, d, bl, dpe);
      bus.dispA = a;
      bus.dispB = b;
      bus.dispC = c;
      bus.dispD = d;
      bus.blank = bl;
      bus.dp_en = dpe;
   endtask

   task automatic wait_frame();
      int k = 0;
      while (bus.frame_tick !== 1'b1 && k < 50) begin
         edges(1);
         k++;
      end
      chk("frame_wait", 7'(bus.frame_tick), 7'd1);
   endtask

   initial begin
      set_digits(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      repeat (3) begin
         edges(1);
         chk("rst_an",  7'(bus.an),         7'h0F);
         chk("rst_seg", bus.seg,            7'h7F);
         chk("rst_dp",  7'(bus.dp),         7'd1);
         chk("rst_ft",  7'(bus.frame_tick), 7'd0);
         set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      set_digits(4'h2, 4'h1, 4'h8, 4'h4, 4'h0, 4'h0);
      rst_n = 1'b1;
      edges(4);
      chk("f1_ft",   7'(bus.frame_tick), 7'd1);
      chk("f1_gap",  7'(bus.an),         7'h0F);
      edges(1);
      chk("a_an",    7'(bus.an),  7'b0000111);
      chk("a_seg",   bus.seg,     7'b0100100);
      chk("a_dp",    7'(bus.dp),  7'd1);
      edges(3);
      chk("ab_gap",  7'(bus.an),  7'h0F);
      edges(1);
      chk("b_an",    7'(bus.an),  7'b0001011);
      chk("b_seg",   bus.seg,     7'b1111001);

      set_digits(4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);
      edges(4);
      chk("c_an",    7'(bus.an),  7'b0001101);
      chk("c_seg",   bus.seg,     7'b0000000);
      edges(4);
      chk("d_an",    7'(bus.an),  7'b0001110);
      chk("d_seg",   bus.seg,     7'b0011001);
      edges(3);
      chk("f2_ft",   7'(bus.frame_tick), 7'd1);
      edges(1);
      chk("f2_a_seg", bus.seg,    7'b0001110);
      chk("f2_ft_clr", 7'(bus.frame_tick), 7'd0);

      set_digits(4'hF, 4'hF, 4'hF, 4'hF, 4'b0001, 4'b1000);
      edges(16);
      chk("bl_a_an",  7'(bus.an), 7'b0000111);
      chk("bl_a_dp",  7'(bus.dp), 7'd0);
      edges(4);
      chk("bl_b_an",  7'(bus.an), 7'b0001011);
      chk("bl_b_dp",  7'(bus.dp), 7'd1);
      edges(8);
      chk("bl_d_an",  7'(bus.an), 7'h0F);
      chk("bl_d_seg", bus.seg,    7'h7F);
      chk("bl_d_dp",  7'(bus.dp), 7'd1);

      edges(12);
      chk("mid_c_an", 7'(bus.an), 7'b0001101);
      rst_n = 1'b0;
      edges(1);
      chk("mid_rst_an",  7'(bus.an),  7'h0F);
      chk("mid_rst_seg", bus.seg,     7'h7F);
      chk("mid_rst_dp",  7'(bus.dp),  7'd1);
      set_digits(4'h2, 4'h1, 4'h8, 4'h4, 4'h0, 4'h0);
      rst_n = 1'b1;
      edges(4);
      chk("re_ft",   7'(bus.frame_tick), 7'd1);
      edges(1);
      chk("re_a_an",  7'(bus.an), 7'b0000111);
      chk("re_a_seg", bus.seg,    7'b0100100);

      for (int v = 0; v < 16; v++) begin
         bus.dispA = 4'(v);
         wait_frame();
         edges(1);
         chk("sweep_seg", bus.seg, hex_ref[v]);
      end

      edges(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

endmodule
